// File: rtl/systolic_weight_loader.sv
// Buffers one ARRAY_DIM x ARRAY_DIM weight tile, then shifts it into the PE array top row in one gap-free burst.
// Optional build macro WLOAD_REVERSE_EN: shift buffered rows in reverse order (upstream presents rows top-first).
module systolic_weight_loader #(
  parameter int unsigned ARRAY_DIM = 4,
  parameter int unsigned DATA_W    = 8
) (
  input  logic                          clock,
  input  logic                          resetn,
  input  logic                          load_start,
  input  logic                          w_valid,
  output logic                          w_ready,
  input  logic [ARRAY_DIM*DATA_W-1:0]   w_data,
  output logic [ARRAY_DIM*DATA_W-1:0]   win,
  output logic [ARRAY_DIM-1:0]          wwrite,
  output logic                          busy,
  output logic                          done
);

  localparam int unsigned ROW_W = ARRAY_DIM * DATA_W;
  localparam int unsigned CNT_W = (ARRAY_DIM > 1) ? $clog2(ARRAY_DIM) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ARRAY_DIM - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FILL   = 3'd1,
    S_SHIFT  = 3'd2,
    S_SETTLE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [ROW_W-1:0] tile_buf [ARRAY_DIM];
  logic [ROW_W-1:0] shift_row;
  logic             fill_fire;

  logic             w_ready_d, busy_d, done_d;
  logic [ARRAY_DIM-1:0] wwrite_d;
  logic [ROW_W-1:0] win_d;

  function automatic logic [CNT_W-1:0] sel(input logic [CNT_W-1:0] k);
`ifdef WLOAD_REVERSE_EN
    return CNT_LAST - k;
`else
    return k;
`endif
  endfunction

  assign fill_fire = (state == S_FILL) && w_valid && w_ready;

  // State and row counter register
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      S_IDLE: begin
        if (load_start) begin
          state_next = S_FILL;
          cnt_next   = '0;
        end
      end
      S_FILL: begin
        if (fill_fire) begin
          if (cnt == CNT_LAST) begin
            state_next = S_SHIFT;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
      end
      S_SHIFT: begin
        if (cnt == CNT_LAST) begin
          state_next = S_SETTLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      S_SETTLE: state_next = S_DONE;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Row feeding the next shift beat; forwards the beat being written this edge (reverse build)
  always_comb begin
    shift_row = tile_buf[sel(cnt_next)];
    if (fill_fire && (sel(cnt_next) == cnt)) begin
      shift_row = w_data;
    end
  end

  // Output values for the coming cycle, derived from the next state
  always_comb begin
    w_ready_d = 1'b0;
    wwrite_d  = '0;
    win_d     = '0;
    busy_d    = (state_next != S_IDLE);
    done_d    = (state_next == S_DONE);
    if (state_next == S_FILL) begin
      w_ready_d = 1'b1;
    end
    if (state_next == S_SHIFT) begin
      wwrite_d = '1;
      win_d    = shift_row;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      w_ready <= 1'b0;
      wwrite  <= '0;
      win     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      w_ready <= w_ready_d;
      wwrite  <= wwrite_d;
      win     <= win_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  // Tile buffer needs no reset: every row is rewritten before it is shifted out
  always_ff @(posedge clock) begin
    if (resetn && fill_fire) begin
      tile_buf[cnt] <= w_data;
    end
  end

endmodule

// File: tb/tb_systolic_weight_loader.sv
// Self-checking bench for systolic_weight_loader: queue-based burst model, PE-array model, literal pins.
// Define WLOAD_REVERSE_EN for both bench and RTL to check the reversed build.
module tb_systolic_weight_loader;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned RW = N * DW;

  logic          clock = 1'b0;
  logic          resetn, load_start, w_valid, w_ready, busy, done;
  logic [RW-1:0] w_data, win;
  logic [N-1:0]  wwrite;

  always #5 clock = ~clock;

  systolic_weight_loader #(.ARRAY_DIM(N), .DATA_W(DW)) dut (
    .clock(clock), .resetn(resetn), .load_start(load_start),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .win(win), .wwrite(wwrite), .busy(busy), .done(done)
  );

  typedef struct packed {
    logic          rdy;
    logic [N-1:0]  ww;
    logic [RW-1:0] wn;
    logic          bsy;
    logic          dn;
  } obs_t;

  obs_t          exp_o, got_o;
  obs_t          sched[$];
  logic [RW-1:0] beats[$];
  logic [RW-1:0] arr[N];
  logic [RW-1:0] tile[N];
  bit            filling, started;
  int            vectors, miscompares, edges, done_pulses, done_edge;

  function automatic obs_t mk(input logic r, input logic [N-1:0] w, input logic [RW-1:0] d,
                              input logic b, input logic dn);
    obs_t o;
    o.rdy = r; o.ww = w; o.wn = d; o.bsy = b; o.dn = dn;
    return o;
  endfunction

  // Model: FILL collects beats; a full tile schedules shift burst, settle, done and the IDLE cycle
  always @(posedge clock) begin
    edges++;
    started = 1'b1;
    if (!resetn) begin
      filling = 1'b0;
      sched.delete();
      beats.delete();
      exp_o = mk(0, '0, '0, 0, 0);
    end else if (sched.size() > 0) begin
      exp_o = sched.pop_front();
    end else if (filling) begin
      exp_o = mk(1, '0, '0, 1, 0);
      if (w_valid) begin
        beats.push_back(w_data);
        if (beats.size() == N) begin
          for (int i = 0; i < N; i++) begin
`ifdef WLOAD_REVERSE_EN
            sched.push_back(mk(0, '1, beats[N-1-i], 1, 0));
`else
            sched.push_back(mk(0, '1, beats[i], 1, 0));
`endif
          end
          sched.push_back(mk(0, '0, '0, 1, 0));
          sched.push_back(mk(0, '0, '0, 1, 1));
          sched.push_back(mk(0, '0, '0, 0, 0));
          beats.delete();
          filling = 1'b0;
          exp_o = sched.pop_front();
        end
      end
    end else if (load_start) begin
      filling = 1'b1;
      exp_o = mk(1, '0, '0, 1, 0);
    end else begin
      exp_o = mk(0, '0, '0, 0, 0);
    end
  end

  // Per-cycle compare plus PE-array shift model fed by the DUT outputs
  always @(negedge clock) begin
    if (started) begin
      got_o = obs_t'({w_ready, wwrite, win, busy, done});
      vectors++;
      if (got_o !== exp_o) begin
        miscompares++;
        $display("FAIL outputs edge %0d: got rdy=%b ww=%h win=%h busy=%b done=%b, want rdy=%b ww=%h win=%h busy=%b done=%b",
                 edges, got_o.rdy, got_o.ww, got_o.wn, got_o.bsy, got_o.dn,
                 exp_o.rdy, exp_o.ww, exp_o.wn, exp_o.bsy, exp_o.dn);
      end
      if (done === 1'b1) begin
        done_pulses++;
        done_edge = edges;
      end
      for (int c = 0; c < N; c++) begin
        if (wwrite[c] === 1'b1) begin
          for (int r = N - 1; r > 0; r--) arr[r][c*DW +: DW] = arr[r-1][c*DW +: DW];
          arr[0][c*DW +: DW] = win[c*DW +: DW];
        end
      end
    end
  end

  task automatic check(input string name, input logic [RW-1:0] got, input logic [RW-1:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One tile load; optional valid gap, stray load_start pulses, and reset on the 2nd SHIFT cycle
  task automatic load_tile(input int gap_at, input int gap_len, input bit poke_fill,
                           input bit poke_shift, input bit rst_shift2, output int hs_edge);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (i == gap_at) begin
        w_valid = 1'b0;
        repeat (gap_len) tick();
      end
      w_valid = 1'b1;
      w_data  = tile[i];
      if (poke_fill && i == 1) load_start = 1'b1;
      tick();
      load_start = 1'b0;
    end
    hs_edge = edges;
    w_valid = 1'b0;
    w_data  = 32'hDEADBEEF;
    if (poke_shift) begin
      tick();
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
    end
    if (rst_shift2) begin
      tick();
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
    end
  endtask

  task automatic check_array(input string name);
    for (int r = 0; r < N; r++) begin
`ifdef WLOAD_REVERSE_EN
      check(name, arr[r], tile[r]);
`else
      check(name, arr[r], tile[N-1-r]);
`endif
    end
`ifdef WLOAD_REVERSE_EN
    check({name, " row0 literal"}, arr[0], 32'h04030201);
    check({name, " row3 literal"}, arr[3], 32'h100F0E0D);
`else
    check({name, " row0 literal"}, arr[0], 32'h100F0E0D);
    check({name, " row3 literal"}, arr[3], 32'h04030201);
`endif
  endtask

  task automatic run_and_check(input string name, input int gap_at, input int gap_len,
                               input bit poke_fill, input bit poke_shift);
    int hs, d0;
    d0 = done_pulses;
    for (int r = 0; r < N; r++) arr[r] = '0;
    load_tile(gap_at, gap_len, poke_fill, poke_shift, 1'b0, hs);
    repeat (12) tick();
    check({name, " done count"}, RW'(done_pulses - d0), RW'(1));
    check({name, " done latency"}, RW'(done_edge - hs), RW'(5));
    check_array(name);
  endtask

  initial begin
    int hs, d0;
    tile[0] = 32'h04030201; tile[1] = 32'h08070605;
    tile[2] = 32'h0C0B0A09; tile[3] = 32'h100F0E0D;
    vectors = 0; miscompares = 0; edges = 0; done_pulses = 0; done_edge = 0;
    resetn = 1'b0; load_start = 1'b0; w_valid = 1'b0; w_data = '0;
    repeat (3) tick();
    resetn  = 1'b1;
    w_valid = 1'b1;
    w_data  = 32'hA5A5A5A5;
    repeat (20) tick();
    check("idle outputs", RW'({w_ready, wwrite, win, busy, done}) , '0);
    check("idle done count", RW'(done_pulses), '0);
    w_valid = 1'b0;
    tick();

    run_and_check("back-to-back", -1, 0, 1'b0, 1'b0);
    run_and_check("valid gap", 1, 3, 1'b0, 1'b0);
    run_and_check("stray load_start", -1, 0, 1'b1, 1'b1);

    d0 = done_pulses;
    load_tile(-1, 0, 1'b0, 1'b0, 1'b1, hs);
    check("abort busy", RW'(busy), '0);
    check("abort wwrite", RW'(wwrite), '0);
    repeat (10) tick();
    check("abort no done", RW'(done_pulses - d0), '0);
    run_and_check("after abort", -1, 0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
